// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: configuration sequencer for the UART baud generator.
// Owns the generator's enable, divisor and rate-select. CPU writes made while
// the generator runs are parked in a shadow register. They are applied only
// once both TX and RX engines are idle. Each apply is a one-cycle
// disable/re-enable, so the generator phase restarts from zero.
// Optional build macro: UPD_TIMEOUT_EN. When defined, a WAIT_IDLE timeout
// forces the apply after TIMEOUT cycles and pulses upd_forced.
module baud_cfg_ctrl #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DVSR = WIDTH'(326),
  parameter int unsigned      TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_dvsr,
  input  logic             cfg_rate_sel,
  output logic             cfg_ready,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             bg_enable,
  output logic [WIDTH-1:0] bg_dvsr,
  output logic             bg_rate_sel,
  output logic             upd_pending,
  output logic             upd_done,
  output logic             cfg_err,
  output logic             upd_forced
);

  // A timeout shorter than two cycles cannot leave a WAIT_IDLE cycle to observe.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("baud_cfg_ctrl: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_IDLE,
    ST_HALT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow_dvsr;
  logic             shadow_rate_sel;

  logic             wr_acc;       // write seen while the port is ready
  logic             wr_legal;     // write would let the generator tick
  logic             wr_ok;        // accepted and legal
  logic             engines_idle;
  logic             timeout_hit;
  logic [WIDTH-1:0] apply_dvsr;   // value committed on an apply from WAIT_IDLE
  logic             apply_rate_sel;

  // NOTE: cfg_ready is the only output decoded combinationally, and it comes
  // from state alone. No input can ripple through to any output.
  assign cfg_ready = (state != ST_HALT);

  assign wr_acc       = cfg_wr && cfg_ready;
  assign wr_legal     = cfg_rate_sel || (cfg_dvsr >= WIDTH'(2));
  assign wr_ok        = wr_acc && wr_legal;
  assign engines_idle = !tx_busy && !rx_busy;

  // A legal write arriving on the apply edge is the last write, so it wins
  // over the shadow.
  assign apply_dvsr     = wr_ok ? cfg_dvsr     : shadow_dvsr;
  assign apply_rate_sel = wr_ok ? cfg_rate_sel : shadow_rate_sel;

`ifdef UPD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

  // Wait counter: cleared on WAIT_IDLE entry, counts every WAIT_IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT_IDLE) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Forced-apply flag: pulses on the HALT cycle when the timeout, not idle
  // engines, caused the apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_forced <= 1'b0;
    end else begin
      upd_forced <= (state == ST_WAIT_IDLE) && cfg_en && !engines_idle &&
                    timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign upd_forced  = 1'b0;
`endif

  // Sequencer: state, shadow, active config and one-cycle status pulses.
  // NOTE: every register here is assigned with <= so that all branches read
  // the pre-edge values of state and shadow, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      bg_enable       <= 1'b0;
      bg_dvsr         <= DEFAULT_DVSR;
      bg_rate_sel     <= 1'b0;
      shadow_dvsr     <= DEFAULT_DVSR;
      shadow_rate_sel <= 1'b0;
      upd_pending     <= 1'b0;
      upd_done        <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      cfg_err  <= wr_acc && !wr_legal;

      case (state)
        ST_IDLE: begin
          if (wr_ok) begin
            bg_dvsr         <= cfg_dvsr;
            bg_rate_sel     <= cfg_rate_sel;
            shadow_dvsr     <= cfg_dvsr;
            shadow_rate_sel <= cfg_rate_sel;
            upd_done        <= 1'b1;
          end
          if (cfg_en) begin
            state     <= ST_RUN;
            bg_enable <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!cfg_en) begin
            state     <= ST_IDLE;
            bg_enable <= 1'b0;
            if (wr_ok) begin
              bg_dvsr         <= cfg_dvsr;
              bg_rate_sel     <= cfg_rate_sel;
              shadow_dvsr     <= cfg_dvsr;
              shadow_rate_sel <= cfg_rate_sel;
              upd_done        <= 1'b1;
            end
          end else if (wr_ok) begin
            shadow_dvsr     <= cfg_dvsr;
            shadow_rate_sel <= cfg_rate_sel;
            upd_pending     <= 1'b1;
            state           <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (wr_ok) begin
            shadow_dvsr     <= cfg_dvsr;
            shadow_rate_sel <= cfg_rate_sel;
          end
          if (!cfg_en || engines_idle || timeout_hit) begin
            state       <= cfg_en ? ST_HALT : ST_IDLE;
            bg_enable   <= 1'b0;
            bg_dvsr     <= apply_dvsr;
            bg_rate_sel <= apply_rate_sel;
            upd_pending <= 1'b0;
            upd_done    <= 1'b1;
          end
        end

        ST_HALT: begin
          state     <= cfg_en ? ST_RUN : ST_IDLE;
          bg_enable <= cfg_en;
        end

        default: begin
          state     <= ST_IDLE;
          bg_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb_baud_cfg_ctrl: directed test-plan sequences followed by randomized
// traffic. All DUT outputs are compared every cycle against a behavioural
// model of the configuration rules. Build with +define+UPD_TIMEOUT_EN to
// exercise the timeout variant; the bench then uses TIMEOUT=8.
module tb_baud_cfg_ctrl;

  localparam int unsigned WIDTH = 16;
`ifdef UPD_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
  localparam bit          TIMEOUT_ON = 1'b1;
`else
  localparam int unsigned TB_TIMEOUT = 1024;
  localparam bit          TIMEOUT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_en, cfg_wr, cfg_rate_sel, tx_busy, rx_busy;
  logic [WIDTH-1:0] cfg_dvsr;
  logic             cfg_ready, bg_enable, bg_rate_sel;
  logic [WIDTH-1:0] bg_dvsr;
  logic             upd_pending, upd_done, cfg_err, upd_forced;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  baud_cfg_ctrl #(
    .WIDTH       (WIDTH),
    .DEFAULT_DVSR(16'd326),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_wr      (cfg_wr),
    .cfg_dvsr    (cfg_dvsr),
    .cfg_rate_sel(cfg_rate_sel),
    .cfg_ready   (cfg_ready),
    .tx_busy     (tx_busy),
    .rx_busy     (rx_busy),
    .bg_enable   (bg_enable),
    .bg_dvsr     (bg_dvsr),
    .bg_rate_sel (bg_rate_sel),
    .upd_pending (upd_pending),
    .upd_done    (upd_done),
    .cfg_err     (cfg_err),
    .upd_forced  (upd_forced)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the generator is either off, on, on-with-a-pending-update,
  // or in its one-cycle restart gap.
  bit        m_on, m_pending, m_gap;
  bit        m_bg_en, m_rs, m_sh_rs, m_done, m_err, m_forced;
  bit [15:0] m_dvsr, m_sh_dvsr;
  int        m_waited;

  task automatic model_reset();
    m_on = 0; m_pending = 0; m_gap = 0;
    m_bg_en = 0; m_dvsr = 16'd326; m_rs = 0;
    m_sh_dvsr = 16'd326; m_sh_rs = 0;
    m_done = 0; m_err = 0; m_forced = 0; m_waited = 0;
  endtask

  task automatic model_step();
    bit accepted, legal, ok, forced_now;
    accepted = cfg_wr && !m_gap;
    legal    = cfg_rate_sel || (cfg_dvsr >= 2);
    ok       = accepted && legal;
    m_done   = 0;
    m_err    = accepted && !legal;
    m_forced = 0;
    if (m_gap) begin
      m_gap   = 0;
      m_on    = cfg_en;
      m_bg_en = cfg_en;
    end else if (!m_on) begin
      if (ok) begin
        m_dvsr = cfg_dvsr; m_rs = cfg_rate_sel; m_done = 1;
      end
      if (cfg_en) begin
        m_on = 1; m_bg_en = 1;
      end
    end else if (!m_pending) begin
      if (!cfg_en) begin
        m_on = 0; m_bg_en = 0;
        if (ok) begin
          m_dvsr = cfg_dvsr; m_rs = cfg_rate_sel; m_done = 1;
        end
      end else if (ok) begin
        m_sh_dvsr = cfg_dvsr; m_sh_rs = cfg_rate_sel;
        m_pending = 1; m_waited = 0;
      end
    end else begin
      if (ok) begin
        m_sh_dvsr = cfg_dvsr; m_sh_rs = cfg_rate_sel;
      end
      forced_now = TIMEOUT_ON && (m_waited + 1 >= TB_TIMEOUT) &&
                   (tx_busy || rx_busy);
      if (!cfg_en || (!tx_busy && !rx_busy) || forced_now) begin
        m_dvsr = m_sh_dvsr; m_rs = m_sh_rs;
        m_pending = 0; m_done = 1; m_bg_en = 0;
        if (cfg_en) begin
          m_gap = 1; m_forced = forced_now;
        end else begin
          m_on = 0;
        end
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic compare_all();
    check("bg_enable",   bg_enable,   m_bg_en);
    check("bg_dvsr",     bg_dvsr,     m_dvsr);
    check("bg_rate_sel", bg_rate_sel, m_rs);
    check("upd_pending", upd_pending, m_pending);
    check("upd_done",    upd_done,    m_done);
    check("cfg_err",     cfg_err,     m_err);
    check("upd_forced",  upd_forced,  m_forced);
    check("cfg_ready",   cfg_ready,   !m_gap);
  endtask

  // One clock: DUT and model both see the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [15:0] d, input logic rs);
    cfg_wr = 1; cfg_dvsr = d; cfg_rate_sel = rs;
    step();
    cfg_wr = 0;
  endtask

  initial begin
    rst_n = 0; cfg_en = 0; cfg_wr = 0; cfg_dvsr = '0; cfg_rate_sel = 0;
    tx_busy = 0; rx_busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bg_enable", bg_enable, 0);
    check("rst_bg_dvsr",   bg_dvsr,   326);
    check("rst_cfg_ready", cfg_ready, 1);
    compare_all();
    rst_n = 1;

    // Enable from IDLE.
    cfg_en = 1;
    step();
    check("en_bg_enable", bg_enable, 1);

    // Buffered update held off by a busy transmitter; last write wins.
    tx_busy = 1;
    write(16'd100, 0);
    write(16'd200, 0);
    steps(20);
    check("wait_pending", upd_pending, 1);
    check("wait_dvsr",    bg_dvsr,     326);
    tx_busy = 0;
    steps(2);
    check("halt_dvsr", bg_dvsr, 200);
    steps(2);

    // Illegal writes rejected; divisor 0 legal in bypass mode.
    write(16'd1, 0);
    check("ill1_err", cfg_err, 1);
    write(16'd0, 0);
    check("ill0_err", cfg_err, 1);
    check("ill_dvsr", bg_dvsr, 200);
    steps(2);
    write(16'd0, 1);
    steps(4);
    check("byp_rate_sel", bg_rate_sel, 1);

    // Dropping cfg_en in WAIT_IDLE applies the shadow immediately.
    rx_busy = 1;
    write(16'd77, 0);
    steps(3);
    cfg_en = 0;
    step();
    check("drop_en_dvsr", bg_dvsr, 77);
    rx_busy = 0;
    steps(2);

    // A write during the HALT cycle is dropped.
    cfg_en = 1;
    step();
    write(16'd88, 0);
    step();
    check("halt_ready", cfg_ready, 0);
    write(16'd99, 0);
    steps(3);
    check("halt_drop_dvsr", bg_dvsr, 88);

    // IDLE write applies directly.
    cfg_en = 0;
    steps(2);
    write(16'd54, 0);
    check("idle_dvsr", bg_dvsr, 54);
    steps(2);

    // Long busy wait: forced by timeout only when the feature is built in.
    cfg_en = 1; tx_busy = 1;
    step();
    write(16'd300, 0);
    steps(1000);
    tx_busy = 0;
    steps(3);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) cfg_en = ~cfg_en;
      cfg_wr       = ($urandom_range(3) == 0);
      cfg_dvsr     = ($urandom_range(1) == 0) ? 16'($urandom_range(3))
                                              : 16'($urandom);
      cfg_rate_sel = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) tx_busy = ~tx_busy;
      if ($urandom_range(7) == 0) rx_busy = ~rx_busy;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
Configuration sequencer for the UART baud generator. It owns the generator's enable, divisor and rate-select inputs. CPU-side divisor/rate writes are held in a shadow register and applied only when the TX and RX engines are idle. Each apply is a clean one-cycle disable/re-enable, so the generator's phase counter restarts at 0 and never divides with a torn divisor.

Parameters:
WIDTH, 16, divisor width; matches the baud generator's divisor width.
DEFAULT_DVSR, 16'd326, active divisor after reset.
TIMEOUT, 1024, WAIT_IDLE cycle limit; used only with UPD_TIMEOUT_EN.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_en  input  1  1 = baud generator should run
cfg_wr  input  1  write strobe for cfg_dvsr/cfg_rate_sel; accepted when cfg_ready=1
cfg_dvsr  input  WIDTH  requested divisor
cfg_rate_sel  input  1  requested rate select (1 = bypass divisor)
cfg_ready  output  1  0 only in HALT; writes with cfg_ready=0 are dropped silently
tx_busy  input  1  TX engine mid-frame
rx_busy  input  1  RX engine mid-frame
bg_enable  output  1  to generator enable
bg_dvsr  output  WIDTH  to generator divisor
bg_rate_sel  output  1  to generator rate_sel
upd_pending  output  1  shadow holds an unapplied write
upd_done  output  1  one-cycle pulse: new config now active
cfg_err  output  1  one-cycle pulse: write rejected as illegal
upd_forced  output  1  one-cycle pulse: apply forced by timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bg_enable=0, bg_dvsr=DEFAULT_DVSR, bg_rate_sel=0.
  - Shadow=DEFAULT_DVSR/0; upd_pending, upd_done, cfg_err, upd_forced all 0.
- Registered outputs: all outputs except cfg_ready, which is decoded from state.
- Legality check:
  - A write with cfg_rate_sel=0 and cfg_dvsr<2 is illegal: the generator would never tick.
  - Illegal write -> cfg_err=1 the next cycle; no state, shadow or active change.
- State IDLE (bg_enable=0):
  - Legal write -> bg_dvsr/bg_rate_sel loaded on the same edge; upd_done=1 the next cycle.
  - cfg_en=1 -> RUN; bg_enable=1 from the next cycle.
  - Simultaneous write and cfg_en=1 -> both take effect on the same edge.
- State RUN (bg_enable=1):
  - Legal write -> shadow loaded, upd_pending=1, go WAIT_IDLE.
  - cfg_en=0 -> IDLE; bg_enable=0 the next cycle. If a legal write arrives on the same edge, it is applied directly as in IDLE.
- State WAIT_IDLE (bg_enable=1):
  - Further legal writes overwrite the shadow (last write wins); no extra upd_done.
  - cfg_en=0 -> IDLE, applying the shadow on that edge; upd_pending=0; upd_done pulses.
  - tx_busy=0 and rx_busy=0 sampled -> HALT. On that edge: bg_enable=0, bg_dvsr/bg_rate_sel<=shadow, upd_pending=0.
- State HALT (exactly 1 cycle):
  - upd_done=1 and cfg_ready=0 during this cycle.
  - Next state is RUN if cfg_en=1 (bg_enable=1), else IDLE.
- Latency: a write in RUN with both engines idle gives WAIT_IDLE at N+1, HALT at N+2 (new config visible, bg_enable=0), RUN at N+3.
- The generator counter is cleared whenever enable=0, so every apply restarts tick phase from 0.
- No combinational path from any input to any output except through cfg_ready (state decode only).

Optional Feature:
UPD_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT+1) clears on WAIT_IDLE entry and counts every WAIT_IDLE cycle. On reaching TIMEOUT-1 with engines still busy, the block forces HALT exactly as in the normal path and also pulses upd_forced on the HALT cycle.
- Undefined: WAIT_IDLE waits indefinitely; upd_forced is tied 0; no counter is synthesised.

Test Plan:
- Reset then release:
  - bg_enable=0, bg_dvsr=326, bg_rate_sel=0, cfg_ready=1, all pulses 0.
  - cfg_en=1 -> bg_enable=1 next cycle.
- IDLE write cfg_dvsr=54 -> bg_dvsr=54 after 1 edge, single upd_done pulse, upd_pending never set.
- RUN, tx_busy=1, write 100, then write 200, then tx_busy=0 after 20 cycles:
  - upd_pending=1 throughout; bg_dvsr stays 326.
  - HALT one cycle after idle: bg_enable=0 one cycle, bg_dvsr=200, one upd_done pulse.
- Illegal writes, cfg_dvsr=1 then 0 with rate_sel=0:
  - cfg_err pulses twice; bg_dvsr and shadow unchanged.
  - cfg_dvsr=0 with rate_sel=1 is accepted.
- WAIT_IDLE with rx_busy=1, drop cfg_en -> IDLE, bg_enable=0, shadow applied, upd_done pulse; write during the HALT cycle is dropped.
- UPD_TIMEOUT_EN, TIMEOUT=8, tx_busy held 1 -> HALT after 8 WAIT_IDLE cycles, upd_forced and upd_done pulse together; without the macro, no HALT after 1000 cycles.
